// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a synchronous FIFO with one-cycle registered read latency.
// Frame: start bit, WIDTH data bits LSB-first, optional parity, STOP_BITS stop bits.
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             fifo_empty,
  output logic             fifo_r_en,
  input  logic [WIDTH-1:0] fifo_r_data,
  output logic             tx,
  output logic             busy
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_ODD   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   shift_q;
  logic [BIT_W-1:0]   bit_q;
  logic [BAUD_W-1:0]  baud_q;
  logic               par_q;
  logic               tx_q;
  logic               baud_end;

  assign baud_end  = (baud_q == BAUD_LAST);
  assign fifo_r_en = (state_q == IDLE) && tx_en && !fifo_empty && !rst;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (fifo_r_en) state_q <= FETCH;
        end
        FETCH: begin
          // Read data arrives one cycle after the pop, so capture it here.
          shift_q <= fifo_r_data;
          par_q   <= (^fifo_r_data) ^ PAR_ODD;
          tx_q    <= 1'b0;
          baud_q  <= '0;
          state_q <= START;
        end
        START: begin
          if (baud_end) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (PARITY_EN != 0) begin
                tx_q    <= par_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (baud_end) begin
            tx_q    <= 1'b1;
            bit_q   <= '0;
            state_q <= STOP;
          end
        end
        STOP: begin
          // bit_q is reused to count stop bits.
          if (baud_end) begin
            if (bit_q == STOP_LAST) state_q <= IDLE;
            else                    bit_q   <= bit_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (state_q inside {START, DATA, PARITY, STOP})
        baud_q <= baud_end ? '0 : baud_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: four instances with different framing, each fed
// by a small behavioural FIFO whose read data is registered one cycle after a pop.
module tb_fifo_uart_tx;

  localparam int unsigned NI = 4;
  localparam int unsigned CPB_T  [NI] = '{4, 4, 4, 3};
  localparam int unsigned STOP_T [NI] = '{1, 1, 1, 2};
  localparam int unsigned PEN_T  [NI] = '{0, 1, 1, 0};
  localparam int unsigned PODD_T [NI] = '{0, 0, 1, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0] tx_en = '0;
  logic [NI-1:0] push = '0;
  logic [NI-1:0] r_en, tx, busy, empty;
  logic [7:0]    push_data [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_u
    logic [7:0]  mem [16];
    logic [7:0]  rdata = '0;
    logic [3:0]  wp = '0;
    logic [3:0]  rp = '0;
    int unsigned pops = 0;

    always @(posedge clk) begin
      if (r_en[g]) begin
        rdata <= mem[rp];
        rp    <= rp + 4'd1;
        pops  <= pops + 1;
      end
      if (push[g]) begin
        mem[wp] <= push_data[g];
        wp      <= wp + 4'd1;
      end
    end
    assign empty[g] = (wp == rp);

    fifo_uart_tx #(
      .WIDTH       (8),
      .CLKS_PER_BIT(CPB_T[g]),
      .STOP_BITS   (STOP_T[g]),
      .PARITY_EN   (PEN_T[g]),
      .PARITY_ODD  (PODD_T[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .tx_en      (tx_en[g]),
      .fifo_empty (empty[g]),
      .fifo_r_en  (r_en[g]),
      .fifo_r_data(rdata),
      .tx         (tx[g]),
      .busy       (busy[g])
    );
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_pops [NI] = '{default: 0};
  int unsigned bad;

  typedef struct {
    int unsigned inst;
    logic [7:0]  data;
    logic [15:0] bits;   // expected tx bits, frame bit i at index i
    int unsigned nbits;
    int unsigned cpb;
    string       name;
  } vec_t;
  vec_t vt [4];

  function automatic int unsigned get_pops(input int unsigned i);
    case (i)
      0:       return g_u[0].pops;
      1:       return g_u[1].pops;
      2:       return g_u[2].pops;
      default: return g_u[3].pops;
    endcase
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_byte(input int unsigned i, input logic [7:0] d);
    push_data[i] = d;
    push[i] = 1'b1;
    @(negedge clk);
    push[i] = 1'b0;
  endtask

  task automatic wait_fall(input int unsigned i, input string name);
    int unsigned k;
    k = 0;
    while (tx[i] !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, " start"}, int'(tx[i]), 0);
  endtask

  // Samples every cycle of the frame; one comparison per bit plus one for busy.
  task automatic check_frame(input int unsigned i, input logic [15:0] bits,
                             input int unsigned nbits, input int unsigned cpb,
                             input int drop_cyc, input string name);
    int unsigned mism;
    int unsigned bad_busy;
    bad_busy = 0;
    wait_fall(i, name);
    for (int unsigned b = 0; b < nbits; b++) begin
      mism = 0;
      for (int unsigned c = 0; c < cpb; c++) begin
        if (int'(b * cpb + c) == drop_cyc) tx_en[i] = 1'b0;
        if (tx[i] !== bits[b]) mism++;
        if (busy[i] !== 1'b1) bad_busy++;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d mismatching cycles", name, b), mism, 0);
    end
    chk({name, " busy low cycles"}, bad_busy, 0);
  endtask

  task automatic check_idle(input int unsigned i, input string name);
    chk({name, " idle tx"}, int'(tx[i]), 1);
    chk({name, " idle busy"}, int'(busy[i]), 0);
    chk({name, " pops"}, get_pops(i), exp_pops[i]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 8'hA5, 16'b000000_1_10100101_0, 10, 4, "a5"};
    vt[1] = '{1, 8'h01, 16'b00000_1_1_00000001_0, 11, 4, "par_even"};
    vt[2] = '{2, 8'h01, 16'b00000_1_0_00000001_0, 11, 4, "par_odd"};
    // two stop bits at 3 clocks each: (1+8+2)*3 = 33 cycles
    vt[3] = '{3, 8'h81, 16'b00000_11_10000001_0, 11, 3, "stop2"};

    repeat (3) @(negedge clk);
    tx_en = '1;
    chk("rst r_en forced low", int'(r_en), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset tx", int'(tx), 4'hF);
    chk("reset busy", int'(busy), 0);
    chk("reset r_en", int'(r_en), 0);

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (r_en != '0 || tx != '1 || busy != '0) bad++;
    end
    chk("empty idle bad cycles", bad, 0);

    foreach (vt[k]) begin
      exp_pops[vt[k].inst]++;
      push_byte(vt[k].inst, vt[k].data);
      check_frame(vt[k].inst, vt[k].bits, vt[k].nbits, vt[k].cpb, -1, vt[k].name);
      check_idle(vt[k].inst, vt[k].name);
    end

    // Back-to-back: IDLE and FETCH give exactly two high cycles between frames.
    exp_pops[0] += 2;
    push_byte(0, 8'h00);
    push_byte(0, 8'hFF);
    check_frame(0, 16'b000000_1_00000000_0, 10, 4, -1, "b2b_00");
    chk("b2b gap0 tx", int'(tx[0]), 1);
    chk("b2b gap0 busy", int'(busy[0]), 0);
    chk("b2b gap0 r_en", int'(r_en[0]), 1);
    @(negedge clk);
    chk("b2b gap1 tx", int'(tx[0]), 1);
    chk("b2b gap1 busy", int'(busy[0]), 1);
    chk("b2b gap1 r_en", int'(r_en[0]), 0);
    @(negedge clk);
    chk("b2b gap2 tx", int'(tx[0]), 0);
    check_frame(0, 16'b000000_1_11111111_0, 10, 4, -1, "b2b_ff");
    check_idle(0, "b2b");
    chk("b2b fifo empty", int'(empty[0]), 1);

    tx_en[0] = 1'b0;
    push_byte(0, 8'h3C);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (r_en[0] || busy[0] || !tx[0]) bad++;
    end
    chk("disabled bad cycles", bad, 0);
    chk("disabled pops", get_pops(0), exp_pops[0]);
    tx_en[0] = 1'b1;
    #1;
    chk("enable pop same cycle", int'(r_en[0]), 1);
    exp_pops[0]++;
    check_frame(0, 16'b000000_1_00111100_0, 10, 4, -1, "x3c");
    check_idle(0, "x3c");

    // Drop tx_en during data bit 3 (frame cycles 16..19) with another byte queued.
    exp_pops[0]++;
    push_byte(0, 8'h5A);
    push_byte(0, 8'h11);
    check_frame(0, 16'b000000_1_01011010_0, 10, 4, 18, "x5a");
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (r_en[0] || busy[0] || !tx[0]) bad++;
    end
    chk("tx_en low bad cycles", bad, 0);
    chk("tx_en low pops", get_pops(0), exp_pops[0]);
    chk("tx_en low fifo nonempty", int'(empty[0]), 0);
    push_byte(0, 8'h96);

    // Reset mid-frame: 0x11 is abandoned, 0x96 follows intact.
    tx_en[0] = 1'b1;
    exp_pops[0]++;
    wait_fall(0, "x11");
    repeat (10) @(negedge clk);
    chk("pre-rst tx low", int'(tx[0]), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst tx", int'(tx[0]), 1);
    chk("rst busy", int'(busy[0]), 0);
    chk("rst r_en held low", int'(r_en[0]), 0);
    chk("rst pops", get_pops(0), exp_pops[0]);
    rst = 1'b0;
    #1;
    chk("post-rst pop", int'(r_en[0]), 1);
    exp_pops[0]++;
    check_frame(0, 16'b000000_1_10010110_0, 10, 4, -1, "x96");
    check_idle(0, "x96");
    chk("final fifo empty", int'(empty[0]), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
